// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master sequencer: FSM encoding, the queued
// request record and the apb_to_i2c register addresses.
package apb_pkg;

    localparam int unsigned APB_AW = 4;
    localparam int unsigned APB_DW = 32;

    localparam logic [APB_AW-1:0] I2C_CMD_ADDR  = 4'd2;
    localparam logic [APB_AW-1:0] I2C_DATA_ADDR = 4'd4;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// APB bus between the master sequencer and a completer such as apb_to_i2c.
interface apb_master_ctrl_if #(
    parameter int unsigned ADDRESSWIDTH = 4,
    parameter int unsigned DATAWIDTH    = 32
);
    logic [ADDRESSWIDTH-1:0] PADDR;
    logic [DATAWIDTH-1:0]    PWDATA;
    logic                    PWRITE;
    logic                    PSELx;
    logic                    PENABLE;
    logic [DATAWIDTH-1:0]    PRDATA;
    logic                    PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PSELx, PENABLE,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSELx, PENABLE,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_req_fifo.sv
// Single-clock request FIFO; power-of-two depth so the pointers wrap naturally.
module apb_req_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = do_pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d  = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge PCLK) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: queues read/write requests and issues each as a SETUP/ACCESS
// transfer with a PREADY timeout, returning one in-order response per request.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH = APB_AW,
    parameter int unsigned DATAWIDTH    = APB_DW,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDRESSWIDTH-1:0] req_addr,
    input  logic [DATAWIDTH-1:0]    req_wdata,
    output logic                    rsp_valid,
    output logic [DATAWIDTH-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic                    busy,
    apb_master_ctrl_if.master       apb
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    apb_req_t push_req, head;
    logic     fifo_full, fifo_empty, pop, load;

    apb_state_e              st_q, st_d;
    logic                    psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDRESSWIDTH-1:0] paddr_q, paddr_d;
    logic [DATAWIDTH-1:0]    pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [CntW-1:0]         cnt_q, cnt_d;

    assign push_req = '{write: req_write, addr: APB_AW'(req_addr), wdata: APB_DW'(req_wdata)};

    apb_req_fifo #(
        .Depth (FIFO_DEPTH),
        .Width ($bits(apb_req_t))
    ) u_fifo (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push_i  (req_valid),
        .pop_i   (pop),
        .wdata_i (push_req),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        st_d        = st_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;
        cnt_d       = cnt_q;
        load        = 1'b0;
        unique case (st_q)
            StIdle: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                load      = !fifo_empty;
            end
            StSetup: begin
                penable_d = 1'b1;
                st_d      = StAccess;
            end
            StAccess: begin
                if (apb.PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : apb.PRDATA;
                    load        = !fifo_empty;
                    if (fifo_empty) begin
                        st_d      = StIdle;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    // Abort always passes through IDLE so PSELx drops for a cycle.
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    st_d        = StIdle;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase
        if (load) begin
            st_d      = StSetup;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = head.write;
            paddr_d   = ADDRESSWIDTH'(head.addr);
            pwdata_d  = DATAWIDTH'(head.wdata);
            cnt_d     = '0;
        end
        pop = load;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            st_q        <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            st_q        <= st_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready   = !fifo_full;
    assign busy        = !fifo_empty || (st_q != StIdle) || rsp_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign apb.PSELx   = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

endmodule
